vga_timing_monitor: RTL

//  Receive-side checker for the 640x480 VGA stream (hsync/vsync + 3-3-2 RGB) produced by our display

---
 rtl/vga_timing_monitor.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: rebuilds hc/vc from sync edges,
// locks onto the frame and reports pixels plus timing/blanking faults.
`timescale 1ns/1ps
module vga_timing_monitor #(
   parameter int HPIXELS     = 800,
   parameter int VLINES      = 521,
   parameter int HPULSE      = 96,
   parameter int VPULSE      = 2,
   parameter int HBP         = 144,
   parameter int HFP         = 784,
   parameter int VBP         = 31,
   parameter int VFP         = 511,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [2:0] red_in,
   input  logic [2:0] green_in,
   input  logic [1:0] blue_in,
   output logic       locked,
   output logic       pixel_valid,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic [7:0] pixel_rgb,
   output logic       frame_start,
   output logic       hsync_err,
   output logic       vsync_err,
   output logic       blank_err,
   output logic [7:0] err_count
);

   localparam logic [9:0] C_HLAST  = 10'(HPIXELS - 1);
   localparam logic [9:0] C_HTOUT  = 10'(HPIXELS);
   localparam logic [9:0] C_HPULSE = 10'(HPULSE);
   localparam logic [9:0] C_VLAST  = 10'(VLINES - 1);
   localparam logic [9:0] C_VPULSE = 10'(VPULSE);
   localparam logic [9:0] C_HBP    = 10'(HBP);
   localparam logic [9:0] C_HFP    = 10'(HFP);
   localparam logic [9:0] C_VBP    = 10'(VBP);
   localparam logic [9:0] C_VFP    = 10'(VFP);
   localparam logic [9:0] C_SAT    = 10'h3FF;
   localparam logic [3:0] C_CLAST  = 4'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   logic       r_hs;
   logic       r_vs;
   logic       r_hs_d;
   logic       r_vs_d;
   logic [7:0] r_rgb;
   logic [9:0] r_hc;
   logic [9:0] r_vc;
   state_t     r_state;
   logic [3:0] r_clean;

   logic       r_locked;
   logic       r_pv;
   logic [9:0] r_px;
   logic [9:0] r_py;
   logic [7:0] r_prgb;
   logic       r_fs;
   logic       r_herr;
   logic       r_verr;
   logic       r_berr;
   logic [7:0] r_ecnt;

   logic       w_hfall;
   logic       w_hrise;
   logic       w_vfall;
   logic       w_vrise;
   logic [9:0] w_rhc;
   logic [9:0] w_rvc;
   logic       w_chk;
   logic       w_herr;
   logic       w_verr;
   state_t     w_state_nx;
   logic [3:0] w_clean_nx;
   logic       w_lock_nx;
   logic       w_act;
   logic       w_pv;
   logic       w_fs;
   logic       w_berr;
   logic       w_any;

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_hs   <= 1'b0;
         r_vs   <= 1'b0;
         r_hs_d <= 1'b0;
         r_vs_d <= 1'b0;
         r_rgb  <= 8'd0;
         r_hc   <= 10'd0;
         r_vc   <= 10'd0;
      end else begin
         r_hs   <= hsync_in;
         r_vs   <= vsync_in;
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_rgb  <= {red_in, green_in, blue_in};
         r_hc   <= w_rhc;
         r_vc   <= w_rvc;
      end
   end

   // r_hc/r_vc hold the previous S1 sample; w_rhc/w_rvc are the current one
   always_comb begin
      w_hfall = r_hs_d & ~r_hs;
      w_hrise = ~r_hs_d & r_hs;
      w_vfall = r_vs_d & ~r_vs;
      w_vrise = ~r_vs_d & r_vs;
      w_rhc   = r_hc;
      w_rvc   = r_vc;
      if (w_hfall)
         w_rhc = 10'd0;
      else if (r_hc != C_SAT)
         w_rhc = r_hc + 10'd1;
      if (w_vfall)
         w_rvc = 10'd0;
      else if (w_hfall && (r_vc != C_SAT))
         w_rvc = r_vc + 10'd1;
   end

   always_comb begin
      w_chk  = (r_state != SEARCH);
      w_herr = w_chk &
               ((w_hfall & (r_hc != C_HLAST)) |
                (w_hrise & (w_rhc != C_HPULSE)) |
                (w_rhc == C_HTOUT));
      w_verr = w_chk &
               ((w_vfall & (~w_hfall | (r_vc != C_VLAST))) |
                (w_vrise & (~w_hfall | (w_rvc != C_VPULSE))));
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_state <= SEARCH;
         r_clean <= 4'd0;
      end else begin
         r_state <= w_state_nx;
         r_clean <= w_clean_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_clean_nx = r_clean;
      unique case (r_state)
         SEARCH: begin
            if (w_vfall) begin
               w_state_nx = ALIGN;
               w_clean_nx = 4'd0;
            end
         end
         ALIGN: begin
            if (w_herr | w_verr) begin
               w_state_nx = SEARCH;
            end else if (w_vfall) begin
               w_clean_nx = r_clean + 4'd1;
               if (r_clean == C_CLAST)
                  w_state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (w_herr | w_verr)
               w_state_nx = SEARCH;
         end
         default: begin
            w_state_nx = SEARCH;
            w_clean_nx = 4'd0;
         end
      endcase
   end

   // outputs follow the next state so lock and its errors land together
   always_comb begin
      w_lock_nx = (w_state_nx == LOCKED);
      w_act     = (w_rhc >= C_HBP) && (w_rhc < C_HFP) &&
                  (w_rvc >= C_VBP) && (w_rvc < C_VFP);
      w_pv      = w_lock_nx & w_act;
      w_fs      = w_lock_nx & w_vfall;
      w_berr    = w_lock_nx & ~w_act & (|r_rgb);
      w_any     = w_herr | w_verr | w_berr;
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_locked <= 1'b0;
         r_pv     <= 1'b0;
         r_px     <= 10'd0;
         r_py     <= 10'd0;
         r_prgb   <= 8'd0;
         r_fs     <= 1'b0;
         r_herr   <= 1'b0;
         r_verr   <= 1'b0;
         r_berr   <= 1'b0;
         r_ecnt   <= 8'd0;
      end else begin
         r_locked <= w_lock_nx;
         r_pv     <= w_pv;
         r_px     <= w_pv ? (w_rhc - C_HBP) : 10'd0;
         r_py     <= w_pv ? (w_rvc - C_VBP) : 10'd0;
         r_prgb   <= w_pv ? r_rgb : 8'd0;
         r_fs     <= w_fs;
         r_herr   <= w_herr;
         r_verr   <= w_verr;
         r_berr   <= w_berr;
         if (w_any && (r_ecnt != 8'hFF))
            r_ecnt <= r_ecnt + 8'd1;
      end
   end

   assign locked      = r_locked;
   assign pixel_valid = r_pv;
   assign pixel_x     = r_px;
   assign pixel_y     = r_py;
   assign pixel_rgb   = r_prgb;
   assign frame_start = r_fs;
   assign hsync_err   = r_herr;
   assign vsync_err   = r_verr;
   assign blank_err   = r_berr;
   assign err_count   = r_ecnt;

endmodule
